// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the streaming UART transmitter.
//   tx_state_t      : transmitter FSM state encoding.
//   calc_bit_period : clock cycles per serial bit, integer-truncated.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  function automatic int calc_bit_period(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous first-word-fall-through FIFO feeding the UART
// transmitter. rd_data_o is valid whenever empty_o is low.
// Ports:
//   clk, rstn   : clock, synchronous active-low reset (flushes contents)
//   push_i      : write request; only honoured while ready_o is high
//   wr_data_i   : write data
//   pop_i       : read request; ignored while empty
//   rd_data_o   : head-of-queue word
//   empty_o     : no words held
//   ready_o     : registered "not full", low during reset
//   level_o     : number of words held
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic                     ready_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ready_q;
  logic             push, pop;

  assign push    = push_i && ready_q;
  assign pop     = pop_i && (level_q != '0);
  assign level_d = level_q + LVL_W'(push) - LVL_W'(pop);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      // Ready looks at the next level, so a pop while full reopens the
      // input on the following cycle.
      ready_q <= (level_d != LVL_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (level_q == '0);
  assign ready_o   = ready_q;
  assign level_o   = level_q;

endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: streaming UART transmitter. Words arrive on a valid/ready
// stream into a FIFO and are serialised LSB first as start, data,
// [parity], stop bits. Frames are sent back to back while words are queued.
// Optional parity is compiled in with the macro UART_TX_PARITY_EN.
// Handshake: a word transfers on a rising clk edge where s_valid && s_ready;
//   s_data must stay stable while s_valid is high and s_ready is low.
// Ports:
//   clk, rstn    : clock, synchronous active-low reset
//   s_valid      : input word valid
//   s_ready      : FIFO can accept a word (registered)
//   s_data       : input word
//   par_odd      : 1 = odd parity, 0 = even; latched when a word is popped
//   uart_tx      : serial line, idle high (registered)
//   busy         : frame in flight or FIFO non-empty
//   fifo_level   : words held in the FIFO (registered)
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          par_odd,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BIT_PERIOD = calc_bit_period(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W      = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

  if (BIT_PERIOD < 2) begin : g_bit_period_check
    $error("uart_tx_stream: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_data_bits_check
    $error("uart_tx_stream: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_bits_check
    $error("uart_tx_stream: STOP_BITS must be 1 or 2");
  end

`ifdef UART_TX_PARITY_EN
  localparam tx_state_t AFTER_DATA = PARITY;
`else
  localparam tx_state_t AFTER_DATA = STOP;
`endif

  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 fifo_empty;
  logic                 pop;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push_i    (s_valid),
    .wr_data_i (s_data),
    .pop_i     (pop),
    .rd_data_o (fifo_rd_data),
    .empty_o   (fifo_empty),
    .ready_o   (s_ready),
    .level_o   (fifo_level)
  );

  tx_state_t            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 uart_tx_q;
  logic                 bit_last;
  logic                 frame_last;

`ifdef UART_TX_PARITY_EN
  logic                 par_q;
`else
  logic                 unused_par_odd;
  assign unused_par_odd = par_odd;
`endif

  assign bit_last   = (cnt_q == CNT_W'(BIT_PERIOD - 1));
  assign frame_last = (state_q == STOP) && bit_last && (idx_q == 3'(STOP_BITS - 1));
  // Pop from IDLE, or on the final stop cycle so frames abut with no gap.
  assign pop        = !fifo_empty && ((state_q == IDLE) || frame_last);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      uart_tx_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      // The line follows the state one cycle later; every bit still spans
      // exactly BIT_PERIOD cycles.
      case (state_q)
        START:   uart_tx_q <= 1'b0;
        DATA:    uart_tx_q <= shift_q[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  uart_tx_q <= par_q;
`endif
        default: uart_tx_q <= 1'b1;
      endcase

      if (pop) begin
        shift_q <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
        par_q   <= (^fifo_rd_data) ^ par_odd;
`endif
        cnt_q   <= '0;
        idx_q   <= '0;
        state_q <= START;
      end else if (state_q != IDLE) begin
        cnt_q <= bit_last ? '0 : cnt_q + CNT_W'(1);
        if (bit_last) begin
          case (state_q)
            START: begin
              idx_q   <= '0;
              state_q <= DATA;
            end
            DATA: begin
              shift_q <= shift_q >> 1;
              if (idx_q == 3'(DATA_BITS - 1)) begin
                idx_q   <= '0;
                state_q <= AFTER_DATA;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
              idx_q   <= '0;
              state_q <= STOP;
            end
`endif
            STOP: begin
              if (idx_q == 3'(STOP_BITS - 1)) begin
                idx_q   <= '0;
                state_q <= IDLE;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign uart_tx = uart_tx_q;
  assign busy    = (state_q != IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: directed bench for uart_tx_stream at BIT_PERIOD=10.
// DUT a: 8 data bits, 1 stop, 16-deep FIFO. DUT b: 7 data bits, 2 stops.
module tb_uart_tx_stream;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int BP       = 10;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic       a_valid, a_ready, a_par_odd, a_tx, a_busy;
  logic [7:0] a_data;
  logic [4:0] a_level;

  logic       b_valid, b_ready, b_par_odd, b_tx, b_busy;
  logic [6:0] b_data;
  logic [2:0] b_level;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_stream #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u_dut_a (
    .clk(clk), .rstn(rstn), .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
    .par_odd(a_par_odd), .uart_tx(a_tx), .busy(a_busy), .fifo_level(a_level)
  );

  uart_tx_stream #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_dut_b (
    .clk(clk), .rstn(rstn), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
    .par_odd(b_par_odd), .uart_tx(b_tx), .busy(b_busy), .fifo_level(b_level)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic parity_of(input logic [7:0] d, input int nbits);
    logic p;
    p = 1'b0;
    for (int i = 0; i < nbits; i++) p = p ^ d[i];
    return p;
  endfunction

  // Called just after the pop edge; checks every cycle of one frame.
  task automatic check_frame(input string tag, input logic [7:0] data, input logic podd,
                             input int dbits, input int sbits, input bit sel);
    int   nbits;
    logic exp_bit;
    logic obs;
    nbits = 1 + dbits + PAR + sbits;
    for (int b = 0; b < nbits; b++) begin
      if (b == 0)                         exp_bit = 1'b0;
      else if (b <= dbits)                exp_bit = data[b-1];
      else if (PAR == 1 && b == dbits + 1) exp_bit = parity_of(data, dbits) ^ podd;
      else                                exp_bit = 1'b1;
      for (int c = 0; c < BP; c++) begin
        @(posedge clk); #1;
        obs = sel ? b_tx : a_tx;
        check($sformatf("%s_bit%0d_c%0d", tag, b, c), 32'(obs), 32'(exp_bit));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Returns just after the pop edge (accept at N, pop at N+1).
  task automatic send_a(input logic [7:0] data, input logic podd);
    check("send_a_ready", 32'(a_ready), 32'd1);
    a_data = data; a_par_odd = podd; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    check("accept_level", 32'(a_level), 32'd1);
    check("accept_tx",    32'(a_tx),    32'd1);
    @(posedge clk); #1;
    check("pop_level", 32'(a_level), 32'd0);
    check("pop_tx",    32'(a_tx),    32'd1);
    check("pop_busy",  32'(a_busy),  32'd1);
  endtask

  task automatic send_b(input logic [6:0] data, input logic podd);
    b_data = data; b_par_odd = podd; b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    check("b_accept_level", 32'(b_level), 32'd1);
    @(posedge clk); #1;
    check("b_pop_tx", 32'(b_tx), 32'd1);
  endtask

  logic [7:0] w [17];
  logic       seen_low;

  initial begin
    rstn = 1'b0;
    a_valid = 1'b0; a_data = '0; a_par_odd = 1'b0;
    b_valid = 1'b0; b_data = '0; b_par_odd = 1'b0;
    for (int i = 0; i < 17; i++) w[i] = 8'(i * 13 + 5);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx",    32'(a_tx),    32'd1);
    check("rst_ready", 32'(a_ready), 32'd0);
    check("rst_busy",  32'(a_busy),  32'd0);
    check("rst_level", 32'(a_level), 32'd0);
    check("rst_b_tx",  32'(b_tx),    32'd1);
    rstn = 1'b1;
    check("rel_ready_still_low", 32'(a_ready), 32'd0);
    @(posedge clk); #1;
    check("rel_ready_a", 32'(a_ready), 32'd1);
    check("rel_ready_b", 32'(b_ready), 32'd1);
    check("rel_busy",    32'(a_busy),  32'd0);

    // 1: single 0xA5 frame (LSB first 1,0,1,0,0,1,0,1)
    send_a(8'hA5, 1'b0);
    check_frame("t1", 8'hA5, 1'b0, 8, 1, 1'b0);
    check("t1_busy_after", 32'(a_busy), 32'd0);
    @(posedge clk); #1;
    check("t1_idle_tx", 32'(a_tx), 32'd1);

    // 2: three words back to back, no idle gap between frames
    fork
      begin
        a_valid = 1'b1; a_data = 8'h00;
        @(posedge clk); #1;
        a_data = 8'hFF;
        @(posedge clk); #1;
        check("t2_push_pop_level", 32'(a_level), 32'd1);
        a_data = 8'h3C;
        @(posedge clk); #1;
        a_valid = 1'b0;
        check("t2_level2", 32'(a_level), 32'd2);
      end
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_frame("t2a", 8'h00, 1'b0, 8, 1, 1'b0);
        check_frame("t2b", 8'hFF, 1'b0, 8, 1, 1'b0);
        check_frame("t2c", 8'h3C, 1'b0, 8, 1, 1'b0);
      end
    join
    check("t2_busy_after", 32'(a_busy), 32'd0);

    // 3: 17 words into a 16-deep FIFO, then hold a word against full
    fork
      begin
        for (int i = 0; i < 17; i++) begin
          a_data = w[i]; a_valid = 1'b1;
          @(posedge clk); #1;
        end
        check("t3_full_level", 32'(a_level), 32'd16);
        check("t3_full_ready", 32'(a_ready), 32'd0);
        a_data = 8'hEE;
        repeat (84) begin @(posedge clk); #1; end
        check("t3_hold_level", 32'(a_level), 32'd16);
        check("t3_hold_ready", 32'(a_ready), 32'd0);
        a_valid = 1'b0;
        @(posedge clk); #1;
        check("t3_pop_level", 32'(a_level), 32'd15);
        check("t3_pop_ready", 32'(a_ready), 32'd1);
      end
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 17; i++)
          check_frame($sformatf("t3w%0d", i), w[i], 1'b0, 8, 1, 1'b0);
      end
    join
    check("t3_busy_after", 32'(a_busy), 32'd0);

    // 4: 0x07 with even then odd parity (parity bit 1 then 0 when enabled)
    send_a(8'h07, 1'b0);
    check_frame("t4_even", 8'h07, 1'b0, 8, 1, 1'b0);
    @(posedge clk); #1;
    send_a(8'h07, 1'b1);
    check_frame("t4_odd", 8'h07, 1'b1, 8, 1, 1'b0);
    check("t4_busy_after", 32'(a_busy), 32'd0);

    // 5: 7 data bits, 2 stop bits, 0x55 -> 1,0,1,0,1,0,1 then 20 high cycles
    send_b(7'h55, 1'b0);
    check_frame("t5", 8'h55, 1'b0, 7, 2, 1'b1);
    check("t5_busy_after", 32'(b_busy), 32'd0);

    // 6: reset at the 35th cycle of a 0x5A frame with a word still queued
    send_a(8'h5A, 1'b0);
    a_data = 8'h3C; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    check("t6_queued", 32'(a_level), 32'd1);
    repeat (34) begin @(posedge clk); #1; end
    check("t6_mid_tx", 32'(a_tx), 32'd0);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_tx",    32'(a_tx),    32'd1);
    check("t6_rst_level", 32'(a_level), 32'd0);
    check("t6_rst_busy",  32'(a_busy),  32'd0);
    check("t6_rst_ready", 32'(a_ready), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("t6_ready_back", 32'(a_ready), 32'd1);
    seen_low = 1'b0;
    repeat (150) begin
      @(posedge clk); #1;
      if (a_tx !== 1'b1) seen_low = 1'b1;
    end
    check("t6_line_quiet", 32'(seen_low), 32'd0);
    check("t6_busy_end",   32'(a_busy),   32'd0);
    check("t6_level_end",  32'(a_level),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Parametrised UART transmitter that replaces the fixed 8N1 burst-buffered transmitter. It accepts words on a valid/ready stream into an internal FIFO and serialises them continuously onto `uart_tx` with configurable data width and stop bits, plus optional parity. It sits between command/telemetry logic and the board serial pin.

## Interface
- `CLK_FREQ`, 50000000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in baud.
- `DATA_BITS`, 8: data bits per frame; legal range 5..8.
- `STOP_BITS`, 1: stop bits per frame; 1 or 2.
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥2.
- `clk`  in  1: clock.
- `rstn`  in  1: reset, synchronous, active-low.
- `s_valid`  in  1: input word valid.
- `s_ready`  out  1: FIFO can accept a word.
- `s_data`  in  DATA_BITS: input word, LSB transmitted first.
- `par_odd`  in  1: 1 selects odd parity, 0 selects even; sampled at pop; ignored unless parity is compiled in.
- `uart_tx`  out  1: serial line, idle high.
- `busy`  out  1: a frame is in flight or the FIFO is non-empty.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1: number of words held.

## Operation
- `BIT_PERIOD = CLK_FREQ/BAUD_RATE`, integer-truncated. Elaboration fails if the result is below 2. The bit counter width is sized from `BIT_PERIOD`.
- Push: the FIFO accepts a word when `s_valid && s_ready`. `s_data` must be held while `s_valid && !s_ready`.
- FSM states: IDLE → START → DATA → [PARITY] → STOP.
  - IDLE: if the FIFO is non-empty, pop into the shift register, latch `par_odd`, and go to START.
  - START: drive 0.
  - DATA: drive `shift[0]`, shift right every bit; leave after DATA_BITS bits.
  - PARITY: drive the parity bit (present only with the macro).
  - STOP: drive 1 for STOP_BITS×BIT_PERIOD cycles.
- Back-to-back frames: on the last cycle of STOP, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Simultaneous push and pop: `fifo_level` is unchanged.
- Full: `s_ready`=0 and no push occurs. A pop in the same cycle raises `s_ready` on the next cycle.
- Empty: IDLE holds and `uart_tx`=1.
- Reset mid-frame: on the next edge `uart_tx`=1, the FIFO is flushed, the FSM returns to IDLE, and the partial frame is abandoned.
- `busy` = (state≠IDLE) || (`fifo_level`≠0).

## Timing
- Reset values: `uart_tx`=1, `s_ready`=0, `busy`=0, `fifo_level`=0. `s_ready` rises on the first edge after `rstn` deasserts.
- All outputs are registered except `busy`, which is decoded from registers.
- Latency: with the block idle and empty, a word accepted at edge N pops at edge N+1. `uart_tx` falls at edge N+2.
- Each bit is held exactly BIT_PERIOD cycles.
- Frame length is (1 + DATA_BITS + P + STOP_BITS)×BIT_PERIOD cycles, where P=1 with parity and 0 without.
- Throughput is one frame per frame length while the FIFO is non-empty.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state follows DATA. The parity bit is ^data XOR the latched `par_odd`.
- `UART_TX_PARITY_EN` undefined: PARITY state and logic are absent. Frames are 8N1/8N2-style and `par_odd` is unused.

## Structure
- Package `uart_pkg` holds:
  - `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP).
  - Function `calc_bit_period(clk_freq, baud)`.
- Sub-module `uart_tx_fifo`: synchronous FIFO (DEPTH, WIDTH), with push/pop, full/empty and level outputs. Its read data is valid on the same cycle as `!empty` (first-word fall-through).

## Test plan
All scenarios use CLK_FREQ=1000000, BAUD_RATE=100000 (BIT_PERIOD=10).
1. Push 0xA5 with 8N1 while idle. Expect `uart_tx` low 2 cycles after accept, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high. Frame is 100 cycles and `busy` drops afterwards.
2. Push 0x00, 0xFF, 0x3C back-to-back. Expect three contiguous 100-cycle frames with no idle gap.
3. Push 17 words with FIFO_DEPTH=16 and no drain time. `s_ready`=0 once `fifo_level`=16. The 17th word is accepted only after the first pop, and all 17 words are transmitted in order.
4. With `UART_TX_PARITY_EN` defined, send 0x07 with `par_odd`=0. Expect parity bit 1 and a 110-cycle frame. With `par_odd`=1, expect parity bit 0.
5. DATA_BITS=7, STOP_BITS=2, send 0x55. Expect 7 data bits followed by 20 high cycles, 100 cycles total.
6. Assert `rstn` low for one cycle at the 35th cycle of a frame. Expect `uart_tx`=1 on the next edge, `fifo_level`=0, `busy`=0, and no further transitions on `uart_tx`.
